sent_rx_edge_timer: RTL and testbench



---
 rtl/sent_rx_edge_timer.sv | 213 +++++++++++++++++++++
 tb/tb_sent_rx_edge_timer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sent_rx_edge_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : sent_rx_edge_timer                                         |
// | Description : SENT receiver front end. Synchronizes the raw line,        |
// |               optionally filters glitches, and measures the clk_rx      |
// |               count between consecutive filtered falling edges.         |
// |               Pulses in the calibration window are flagged. An interval |
// |               that saturates the counter is reported as a line timeout. |
// | Option      : define SENT_RX_GLITCH_FILTER_EN to enable the run-length   |
// |               glitch filter. Without it line_o is the registered        |
// |               synchronizer output.                                      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module sent_rx_edge_timer #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3,
  parameter int CNT_W       = 12,
  parameter int CAL_MIN     = 134,
  parameter int CAL_MAX     = 202
) (
  input  logic             clk_rx,
  input  logic             reset_rx,
  input  logic             enable_i,
  input  logic             sent_rx_i,
  output logic             line_o,
  output logic             fall_edge_o,
  output logic             pulse_valid_o,
  output logic [CNT_W-1:0] pulse_len_o,
  output logic             cal_flag_o,
  output logic             timeout_o,
  output logic             frame_active_o
);

  // Measurement states: HUNT waits for a first edge, MEASURE times intervals.
  localparam logic [0:0] c_st_hunt    = 1'b0;
  localparam logic [0:0] c_st_measure = 1'b1;

  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_cal_min = CNT_W'(CAL_MIN);
  localparam logic [CNT_W-1:0] c_cal_max = CNT_W'(CAL_MAX);

  // Elaboration-time sanity checks on the configuration.
  if (SYNC_STAGES < 2) begin : g_bad_sync_stages
    $error("sent_rx_edge_timer: SYNC_STAGES must be at least 2");
  end
  if (FILTER_LEN < 1) begin : g_bad_filter_len
    $error("sent_rx_edge_timer: FILTER_LEN must be at least 1");
  end

  // --------------------------------------------------------------------------
  // Synchronizer
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_s;

  // Shift the raw line through the synchronizer chain; idles high.
  always_ff @(posedge clk_rx) begin
    if (reset_rx) begin
      sync_q <= {SYNC_STAGES{1'b1}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sent_rx_i};
    end
  end

  assign sync_s = sync_q[SYNC_STAGES-1];

  // --------------------------------------------------------------------------
  // Line conditioning
  // --------------------------------------------------------------------------
  logic line_q;
  logic line_d;

`ifdef SENT_RX_GLITCH_FILTER_EN
  // Run counter only ever needs to hold 0 .. FILTER_LEN-1: the line flips on
  // the cycle the run would reach FILTER_LEN, which clears it again.
  localparam int               RUN_W      = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [RUN_W-1:0] c_run_last = RUN_W'(FILTER_LEN - 1);

  logic [RUN_W-1:0] run_q;
  logic [RUN_W-1:0] run_d;

  // Accept a new level only after FILTER_LEN consecutive differing samples.
  always_comb begin
    run_d  = '0;
    line_d = line_q;
    if (sync_s != line_q) begin
      if (run_q == c_run_last) begin
        line_d = sync_s;
      end else begin
        run_d = run_q + 1'b1;
      end
    end
  end

  // Register the glitch-filter run length.
  always_ff @(posedge clk_rx) begin
    if (reset_rx) begin
      run_q <= '0;
    end else begin
      run_q <= run_d;
    end
  end
`else
  // Without the filter every synchronized transition is taken directly.
  always_comb begin
    line_d = sync_s;
  end
`endif

  logic fall_q;

  // Register the conditioned line and strobe on its 1->0 transitions, so the
  // strobe coincides with the first cycle line_o reads low.
  always_ff @(posedge clk_rx) begin
    if (reset_rx) begin
      line_q <= 1'b1;
      fall_q <= 1'b0;
    end else begin
      line_q <= line_d;
      fall_q <= line_q & ~line_d;
    end
  end

  // --------------------------------------------------------------------------
  // Interval measurement
  // --------------------------------------------------------------------------
  logic [0:0]       state_q;
  logic [0:0]       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             valid_q;
  logic             valid_d;
  logic             timeout_q;
  logic             timeout_d;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] len_d;
  logic             cal_q;
  logic             cal_d;

  // Next-state logic: disable beats everything, an edge beats saturation.
  // The counter reads 1 in the cycle after an edge, so its value at the next
  // edge is exactly the edge-to-edge distance in clocks.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    valid_d   = 1'b0;
    timeout_d = 1'b0;
    len_d     = len_q;
    cal_d     = cal_q;
    case (state_q)
      c_st_hunt: begin
        cnt_d = '0;
        if (enable_i && fall_q) begin
          state_d = c_st_measure;
          cnt_d   = c_cnt_one;
        end
      end
      c_st_measure: begin
        if (!enable_i) begin
          // Drop the interval in progress without reporting it.
          state_d = c_st_hunt;
          cnt_d   = '0;
        end else if (fall_q) begin
          valid_d = 1'b1;
          len_d   = cnt_q;
          cal_d   = (cnt_q >= c_cal_min) && (cnt_q <= c_cal_max);
          cnt_d   = c_cnt_one;
        end else if (cnt_q == c_cnt_max) begin
          // Line has been quiet for the full counter range.
          timeout_d = 1'b1;
          state_d   = c_st_hunt;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = c_st_hunt;
        cnt_d   = '0;
      end
    endcase
  end

  // Register measurement state, counter, strobes and the held pulse result.
  always_ff @(posedge clk_rx) begin
    if (reset_rx) begin
      state_q   <= c_st_hunt;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      len_q     <= '0;
      cal_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      len_q     <= len_d;
      cal_q     <= cal_d;
    end
  end

  assign line_o         = line_q;
  assign fall_edge_o    = fall_q;
  assign pulse_valid_o  = valid_q;
  assign pulse_len_o    = len_q;
  assign cal_flag_o     = cal_q;
  assign timeout_o      = timeout_q;
  assign frame_active_o = (state_q == c_st_measure);

endmodule
`default_nettype wire

// File: tb/tb_sent_rx_edge_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_sent_rx_edge_timer                                      |
// | Description : Self-checking bench for sent_rx_edge_timer. A cycle-level |
// |               reference derives the line from sample windows and the    |
// |               intervals from edge cycle numbers.                         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_sent_rx_edge_timer;

  localparam int S    = 2;
  localparam int F    = 3;
  localparam int W    = 12;
  localparam int CMIN = 134;
  localparam int CMAX = 202;
  localparam int MAXV = (1 << W) - 1;
  localparam int HN   = 32768;

  logic         clk_rx = 1'b0;
  logic         reset_rx;
  logic         enable_i;
  logic         sent_rx_i;
  logic         line_o;
  logic         fall_edge_o;
  logic         pulse_valid_o;
  logic [W-1:0] pulse_len_o;
  logic         cal_flag_o;
  logic         timeout_o;
  logic         frame_active_o;

  sent_rx_edge_timer #(
    .SYNC_STAGES (S),
    .FILTER_LEN  (F),
    .CNT_W       (W),
    .CAL_MIN     (CMIN),
    .CAL_MAX     (CMAX)
  ) dut (
    .clk_rx         (clk_rx),
    .reset_rx       (reset_rx),
    .enable_i       (enable_i),
    .sent_rx_i      (sent_rx_i),
    .line_o         (line_o),
    .fall_edge_o    (fall_edge_o),
    .pulse_valid_o  (pulse_valid_o),
    .pulse_len_o    (pulse_len_o),
    .cal_flag_o     (cal_flag_o),
    .timeout_o      (timeout_o),
    .frame_active_o (frame_active_o)
  );

  always #5 clk_rx = ~clk_rx;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference state: raw input history, last reset cycle, line/edge and
  // the measurement in progress expressed as the cycle of the last edge.
  bit hist [HN];
  int rst_cyc = 0;
  bit m_line  = 1'b1;
  bit m_fall  = 1'b0;
  bit m_pv    = 1'b0;
  bit m_to    = 1'b0;
  bit m_cal   = 1'b0;
  bit m_act   = 1'b0;
  int m_len   = 0;
  int m_last  = 0;

  int seen_pv   = 0;
  int seen_fall = 0;
  int seen_to   = 0;
  int lens [$];
  bit cals [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Synchronized sample seen during cycle m: raw input S cycles earlier,
  // or the idle level while the synchronizer still holds its reset value.
  function automatic bit syn(input int m);
    if (m - S >= rst_cyc + 1) return hist[m - S];
    return 1'b1;
  endfunction

  // Conditioned line level for cycle c given the level in cycle c-1.
  function automatic bit next_line(input int c);
`ifdef SENT_RX_GLITCH_FILTER_EN
    for (int k = 1; k <= F; k++) begin
      if (syn(c - k) == m_line) return m_line;
    end
    return ~m_line;
`else
    return syn(c - 1);
`endif
  endfunction

  // Drive one cycle of inputs, advance the reference, compare all outputs.
  task automatic step(input bit din, input bit en, input bit rst);
    int p;
    bit nl;
    if (cyc >= HN - 1) begin
      $display("FAIL history: cycle budget %0d exhausted", HN);
      $fatal(1, "bench cycle budget exhausted");
    end
    sent_rx_i = din;
    enable_i  = en;
    reset_rx  = rst;
    hist[cyc] = din;
    @(posedge clk_rx);
    #1;
    p = cyc;
    cyc++;
    m_pv = 1'b0;
    m_to = 1'b0;
    if (rst) begin
      rst_cyc = p;
      m_line  = 1'b1;
      m_fall  = 1'b0;
      m_len   = 0;
      m_cal   = 1'b0;
      m_act   = 1'b0;
    end else begin
      nl = next_line(cyc);
      if (m_act) begin
        if (!en) begin
          m_act = 1'b0;
        end else if (m_fall) begin
          m_pv   = 1'b1;
          m_len  = p - m_last;
          m_cal  = (m_len >= CMIN) && (m_len <= CMAX);
          m_last = p;
        end else if (p - m_last == MAXV) begin
          m_to  = 1'b1;
          m_act = 1'b0;
        end
      end else if (m_fall && en) begin
        m_act  = 1'b1;
        m_last = p;
      end
      m_fall = m_line & ~nl;
      m_line = nl;
    end
    chk("line", line_o, m_line);
    chk("fall_edge", fall_edge_o, m_fall);
    chk("pulse_valid", pulse_valid_o, m_pv);
    chk("pulse_len", pulse_len_o, m_len);
    chk("cal_flag", cal_flag_o, m_cal);
    chk("timeout", timeout_o, m_to);
    chk("frame_active", frame_active_o, m_act);
    if (pulse_valid_o === 1'b1) begin
      seen_pv++;
      lens.push_back(int'(pulse_len_o));
      cals.push_back(cal_flag_o);
    end
    if (fall_edge_o === 1'b1) seen_fall++;
    if (timeout_o === 1'b1) seen_to++;
  endtask

  // Raw falling edge now, 6-cycle low pulse, high for the rest of gap.
  task automatic edge_gap(input int gap, input bit en);
    for (int i = 0; i < gap; i++) step((i < 6) ? 1'b0 : 1'b1, en, 1'b0);
  endtask

  initial begin
    int gaps [7];
    bit cexp [7];
    int base_pv;
    int base_to;
    int base_fall;
    int stop_cyc;
    bit lvl;
    bit en_r;
    int run;

    gaps = '{168, 36, 203, 134, 202, 133, 135};
    cexp = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    // Reset, then idle-high line.
    repeat (3) step(1'b1, 1'b0, 1'b1);
    chk("reset_line", line_o, 1'b1);
    chk("reset_len", pulse_len_o, 0);
    repeat (100) step(1'b1, 1'b1, 1'b0);
    chk("idle_strobes", seen_fall + seen_pv + seen_to, 0);
    chk("idle_frame", frame_active_o, 1'b0);
    chk("idle_line", line_o, 1'b1);

    // Calibration / nibble / window-boundary intervals.
    lens.delete();
    cals.delete();
    for (int i = 0; i < 7; i++) edge_gap(gaps[i], 1'b1);
    edge_gap(40, 1'b1);
    chk("train_count", lens.size(), 7);
    for (int i = 0; i < 7; i++) begin
      if (i < lens.size()) begin
        chk("train_len", lens[i], gaps[i]);
        chk("train_cal", cals[i], cexp[i]);
      end
    end

    // Two-cycle low glitch.
    base_fall = seen_fall;
    repeat (2) step(1'b0, 1'b1, 1'b0);
    repeat (20) step(1'b1, 1'b1, 1'b0);
`ifdef SENT_RX_GLITCH_FILTER_EN
    chk("glitch_fall", seen_fall - base_fall, 0);
`else
    chk("glitch_fall", seen_fall - base_fall, 1);
`endif

    // Line quiet after an edge: single timeout, back to HUNT.
    base_to = seen_to;
    edge_gap(4200, 1'b1);
    chk("timeout_count", seen_to - base_to, 1);
    chk("timeout_frame", frame_active_o, 1'b0);
    base_pv = seen_pv;
    edge_gap(50, 1'b1);
    chk("after_timeout_pv", seen_pv - base_pv, 0);
    chk("after_timeout_frame", frame_active_o, 1'b1);

    // Edge on the saturation cycle wins; one cycle later is a timeout.
    lens.delete();
    cals.delete();
    base_to = seen_to;
    edge_gap(4095, 1'b1);
    edge_gap(4096, 1'b1);
    edge_gap(50, 1'b1);
    edge_gap(50, 1'b1);
    chk("sat_count", lens.size(), 3);
    if (lens.size() == 3) begin
      chk("sat_len0", lens[0], 50);
      chk("sat_len1", lens[1], MAXV);
      chk("sat_len2", lens[2], 50);
    end
    chk("sat_timeouts", seen_to - base_to, 1);

    // Reset in the middle of a frame.
    step(1'b1, 1'b1, 1'b1);
    chk("rst_mid_frame", frame_active_o, 1'b0);
    base_pv = seen_pv;
    edge_gap(60, 1'b1);
    chk("rst_first_edge_pv", seen_pv - base_pv, 0);
    edge_gap(60, 1'b1);
    chk("rst_second_edge_pv", seen_pv - base_pv, 1);
    chk("rst_second_len", pulse_len_o, 60);

    // Enable dropped for one cycle, then edges ignored while disabled.
    step(1'b1, 1'b0, 1'b0);
    chk("dis_frame", frame_active_o, 1'b0);
    edge_gap(30, 1'b0);
    chk("dis_edge_frame", frame_active_o, 1'b0);
    base_pv = seen_pv;
    edge_gap(70, 1'b1);
    chk("dis_first_edge_pv", seen_pv - base_pv, 0);
    edge_gap(70, 1'b1);
    chk("dis_second_edge_pv", seen_pv - base_pv, 1);
    chk("dis_second_len", pulse_len_o, 70);

    // Random line activity with occasional disable and reset.
    stop_cyc = cyc + 4000;
    lvl = 1'b1;
    while (cyc < stop_cyc) begin
      lvl  = ~lvl;
      en_r = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 9) == 0) run = $urandom_range(100, 300);
      else run = $urandom_range(1, 12);
      for (int i = 0; i < run; i++) begin
        step(lvl, en_r, ($urandom_range(0, 799) == 0));
      end
    end
    repeat (20) step(1'b1, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
